// File: rtl/led_scan_ctrl_pkg.sv
// Shared constants for the LED scan controller: segment patterns and select polarity.
package led_scan_ctrl_pkg;

    localparam logic [6:0] SEG_E   = 7'b1001111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Segment patterns {a,b,c,d,e,f,g} for BCD digits 0..9, 1 = lit.
    localparam logic [6:0] SEG_TABLE [0:9] = '{
        7'b1111110,
        7'b0110000,
        7'b1101101,
        7'b1111001,
        7'b0110011,
        7'b1011011,
        7'b1011111,
        7'b1110000,
        7'b1111111,
        7'b1111011
    };

    localparam logic SEL_ACTIVE = 1'b0;

endpackage

// File: rtl/led_scan_ctrl_if.sv
// Host write port of the scan controller: frame data, blank mask and ready handshake.
interface led_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    import led_scan_ctrl_pkg::*;

    logic                  wr_en;
    logic [4*DIGITS-1:0]   wr_data;
    logic [DIGITS-1:0]     wr_blank;
    logic                  wr_ready;

    modport master (output wr_en, output wr_data, output wr_blank, input wr_ready);
    modport slave  (input wr_en, input wr_data, input wr_blank, output wr_ready);

endinterface

// File: rtl/led_scan_ctrl_seg_decode.sv
// BCD to 7-segment decode; any non-BCD code shows "E".
module seg_decode (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    import led_scan_ctrl_pkg::*;

    // Table lookup for 0..9, "E" for 10..15.
    always_comb begin
        seg = SEG_E;
        if (bcd <= 4'd9) begin
            seg = SEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/led_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a double-buffered BCD frame.
// New frames commit only at a frame wrap (or immediately while dark) so a frame
// is never shown half old, half new.
module led_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    led_scan_ctrl_if.slave    wr,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] sel,
    output logic              frame_done
);
    import led_scan_ctrl_pkg::*;

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic                   tick;
    logic                   boundary;
    logic                   pend_valid;
    logic [4*DIGITS-1:0]    pend_data;
    logic [DIGITS-1:0]      pend_blank;
    logic [4*DIGITS-1:0]    act_data;
    logic [DIGITS-1:0]      act_blank;
    logic [3:0]             cur_nibble;
    logic                   cur_blank;
    logic [6:0]             dec_seg;
    logic [DIGITS-1:0]      sel_next;

    assign tick     = enable && (cnt == CNT_LAST);
    assign boundary = tick && (idx == IDX_LAST);
    assign wr.wr_ready = !pend_valid;

    // Select the active nibble/blank bit and the one-cold strobe for the current slot.
    always_comb begin
        cur_nibble = 4'd0;
        cur_blank  = 1'b1;
        sel_next   = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nibble  = act_data[4*i +: 4];
                cur_blank   = act_blank[i];
                sel_next[i] = SEL_ACTIVE;
            end
        end
    end

    seg_decode u_seg_decode (
        .bcd (cur_nibble),
        .seg (dec_seg)
    );

    // Prescaler and digit index; both parked at 0 while dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (!enable) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end
        end
    end

    // Pending/active frame buffers; a write needs an empty pending slot, so it
    // can never coincide with a commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_data  <= '0;
            pend_blank <= '0;
            act_data   <= '0;
            act_blank  <= '1;
        end else if (pend_valid && (boundary || !enable)) begin
            act_data   <= pend_data;
            act_blank  <= pend_blank;
            pend_valid <= 1'b0;
        end else if (wr.wr_en && !pend_valid) begin
            pend_data  <= wr.wr_data;
            pend_blank <= wr.wr_blank;
            pend_valid <= 1'b1;
        end
    end

    // Registered pin drive, one cycle behind the digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_OFF;
            sel        <= '1;
            frame_done <= 1'b0;
        end else if (!enable) begin
            seg        <= SEG_OFF;
            sel        <= '1;
            frame_done <= 1'b0;
        end else begin
            seg        <= cur_blank ? SEG_OFF : dec_seg;
            sel        <= sel_next;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl (DIGITS=4, DIV=4): frame-position model plus directed checks.
module tb_led_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int FRAME  = DIGITS * DIV;

    localparam logic [6:0] S_E   = 7'b1001111;
    localparam logic [6:0] S_OFF = 7'b0000000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic [6:0]        seg;
    logic [DIGITS-1:0] sel;
    logic              frame_done;

    int vectors = 0;
    int miscompares = 0;

    led_scan_ctrl_if #(.DIGITS(DIGITS)) wr_if ();

    led_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr         (wr_if),
        .seg        (seg),
        .sel        (sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return S_E;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Model: position in the frame comes from the count of enabled edges since
    // enable rose; the frame wraps every FRAME enabled edges.
    int                k;
    logic [15:0]       m_act;
    logic [3:0]        m_actb;
    logic [15:0]       m_pend;
    logic [3:0]        m_pendb;
    logic              m_pv;
    logic [6:0]        exp_seg;
    logic [DIGITS-1:0] exp_sel;
    logic              exp_fd;
    logic              exp_ready;

    always @(posedge clk or negedge rst_n) begin : model
        int   d;
        logic wrap;
        logic commit;
        logic accept;
        if (!rst_n) begin
            k = 0;
            m_act = '0;
            m_actb = '1;
            m_pend = '0;
            m_pendb = '0;
            m_pv = 1'b0;
            exp_seg = S_OFF;
            exp_sel = '1;
            exp_fd = 1'b0;
            exp_ready = 1'b1;
        end else begin
            if (enable) begin
                k = k + 1;
                d = ((k - 1) / DIV) % DIGITS;
                exp_sel = ~(DIGITS'(1) << d);
                exp_seg = m_actb[d] ? S_OFF : ref_seg(m_act[4*d +: 4]);
                wrap = ((k % FRAME) == 0);
            end else begin
                k = 0;
                exp_sel = '1;
                exp_seg = S_OFF;
                wrap = 1'b0;
            end
            exp_fd = wrap;
            commit = m_pv && (!enable || wrap);
            accept = wr_if.wr_en && !m_pv;
            if (commit) begin
                m_act = m_pend;
                m_actb = m_pendb;
                m_pv = 1'b0;
            end
            if (accept) begin
                m_pend = wr_if.wr_data;
                m_pendb = wr_if.wr_blank;
                m_pv = 1'b1;
            end
            exp_ready = !m_pv;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("seg", {25'd0, seg}, {25'd0, exp_seg});
            check("sel", {28'd0, sel}, {28'd0, exp_sel});
            check("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
            check("wr_ready", {31'd0, wr_if.wr_ready}, {31'd0, exp_ready});
        end
    end

    task automatic write(input logic [15:0] d, input logic [3:0] b);
        @(negedge clk);
        wr_if.wr_en = 1'b1;
        wr_if.wr_data = d;
        wr_if.wr_blank = b;
        @(negedge clk);
        wr_if.wr_en = 1'b0;
    endtask

    task automatic wait_fd();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 200);
        check("frame_done_seen", {31'd0, frame_done}, 32'd1);
    endtask

    // Wait for the next frame wrap, then pin each slot's select and segments.
    task automatic check_frame(input logic [27:0] s);
        logic [DIGITS-1:0] want_sel;
        wait_fd();
        for (int i = 0; i < DIGITS; i++) begin
            @(negedge clk);
            want_sel = ~(DIGITS'(1) << i);
            check("lit_sel", {28'd0, sel}, {28'd0, want_sel});
            check("lit_seg", {25'd0, seg}, {25'd0, s[7*i +: 7]});
            repeat (DIV - 1) @(negedge clk);
        end
        check("lit_ready", {31'd0, wr_if.wr_ready}, 32'd1);
    endtask

    initial begin
        int fd_count;
        wr_if.wr_en = 1'b0;
        wr_if.wr_data = '0;
        wr_if.wr_blank = '0;

        #12;
        check("rst_seg", {25'd0, seg}, 32'd0);
        check("rst_sel", {28'd0, sel}, 32'hF);
        check("rst_ready", {31'd0, wr_if.wr_ready}, 32'd1);
        check("rst_fd", {31'd0, frame_done}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;
        fd_count = 0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (frame_done) fd_count++;
        end
        check("fd_count", fd_count, 32'd3);

        write(16'h4321, 4'b0000);
        check("ready_drop", {31'd0, wr_if.wr_ready}, 32'd0);
        check("no_tear", {25'd0, seg}, 32'd0);
        check_frame({7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000});

        write(16'hFA09, 4'b0000);
        check_frame({S_E, S_E, 7'b1111110, 7'b1111011});

        @(negedge clk);
        wr_if.wr_en = 1'b1;
        wr_if.wr_data = 16'h1111;
        wr_if.wr_blank = 4'b0000;
        @(negedge clk);
        check("second_wr_ready", {31'd0, wr_if.wr_ready}, 32'd0);
        wr_if.wr_data = 16'h2222;
        @(negedge clk);
        wr_if.wr_en = 1'b0;
        check_frame({7'b0110000, 7'b0110000, 7'b0110000, 7'b0110000});
        check_frame({7'b0110000, 7'b0110000, 7'b0110000, 7'b0110000});

        write(16'h8888, 4'b0100);
        check_frame({7'b1111111, S_OFF, 7'b1111111, 7'b1111111});

        @(negedge clk);
        enable = 1'b0;
        wr_if.wr_en = 1'b1;
        wr_if.wr_data = 16'h5678;
        wr_if.wr_blank = 4'b0000;
        @(negedge clk);
        wr_if.wr_en = 1'b0;
        check("dark_sel", {28'd0, sel}, 32'hF);
        check("dark_seg", {25'd0, seg}, 32'd0);
        check("dark_pending", {31'd0, wr_if.wr_ready}, 32'd0);
        @(negedge clk);
        check("dark_commit", {31'd0, wr_if.wr_ready}, 32'd1);
        enable = 1'b1;
        @(negedge clk);
        check("reen_sel", {28'd0, sel}, 32'hE);
        check("reen_seg", {25'd0, seg}, {25'd0, 7'b1111111});

        repeat (10) @(negedge clk);
        write(16'h3333, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_sel", {28'd0, sel}, 32'hF);
        check("async_seg", {25'd0, seg}, 32'd0);
        check("async_fd", {31'd0, frame_done}, 32'd0);
        check("async_ready", {31'd0, wr_if.wr_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * FRAME) @(negedge clk);
        check("discarded_seg", {25'd0, seg}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-select 7-segment digits that share one segment bus. It holds a double-buffered frame of BCD digits, steps a digit-select strobe at a programmable refresh rate, and drives each digit's segments through the team's BCD-to-7-segment decode. It sits between the host logic that writes the values and the board's segment and select pins.

Parameters:
DIGITS, 4, number of multiplexed digits (2..8)
DIV, 50000, clk cycles per digit slot (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = scan running; 0 = display dark
wr_en  in  1  host write strobe
wr_data  in  4*DIGITS  BCD nibbles; nibble i (bits 4i+3:4i) = digit i
wr_blank  in  DIGITS  1 = digit i blanked
wr_ready  out  1  1 = pending buffer empty, write accepted
seg  out  7  {a,b,c,d,e,f,g}, 1 = segment lit
sel  out  DIGITS  digit select, active-low, one-cold while scanning
frame_done  out  1  one-cycle pulse at each frame wrap

Behaviour:
- Reset (rst_n low, async):
  - Prescaler = 0, digit index = 0, pending_valid = 0.
  - Active data = 0, active blank = all 1.
  - seg = 0, sel = all 1, wr_ready = 1, frame_done = 0.
- Prescaler:
  - Counts 0..DIV-1 while enable=1, then wraps to 0.
  - tick = (count == DIV-1).
- Digit index:
  - Advances on tick and wraps DIGITS-1 -> 0.
  - The tick that wraps it is the frame boundary.
  - frame_done = 1 for exactly the cycle after the boundary tick.
- Outputs are registered, with one cycle of latency from the index:
  - sel[idx] = 0, all other sel bits = 1.
  - seg = decode(active nibble idx), or 0 if active blank[idx] = 1.
- Decode:
  - 0..9 map as 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011.
  - Codes 10..15 map to "E" = 1001111.
- Write handshake:
  - wr_ready = !pending_valid.
  - wr_en && wr_ready captures wr_data/wr_blank into the pending buffer and sets pending_valid.
  - wr_en while wr_ready = 0 is ignored; no stall and no error.
- Commit:
  - At a frame boundary with pending_valid = 1, pending is copied to active and pending_valid clears.
  - The new frame is therefore first shown starting with digit 0; there is no mid-frame tearing.
- Simultaneous events:
  - wr_en with wr_ready = 1 in the same cycle as a boundary: the write lands in pending and commits at the next boundary.
  - wr_en in the same cycle as a commit (wr_ready = 0): the write is ignored.
- enable = 0:
  - Prescaler and index held at 0.
  - sel = all 1, seg = 0, frame_done = 0.
  - A pending frame commits on the next cycle, so the commit does not wait for a boundary.
- enable rising: digit 0 is driven on the next registered cycle; the first tick occurs DIV cycles later.
- Reset mid-frame or mid-handshake: pending data is discarded and all state returns to reset values immediately.

Decomposition:
- Shared package:
  - SEG_E = 7'b1001111, SEG_OFF = 7'b0000000.
  - The 10-entry digit segment table as constants.
  - SEL_ACTIVE = 1'b0.
- Sub-module seg_decode: combinational, 4-bit BCD in, 7-bit segments out, using the package table with "E" as default. It is instantiated once, on the muxed active nibble.
- All remaining logic lives in led_scan_ctrl: prescaler, index counter, pending/active buffers, output registers.

Test Plan (DIGITS=4, DIV=4):
- Reset then enable=1, no write -> sel cycles 1110, 1101, 1011, 0111, each held 4 cycles; seg = 0 throughout (all blanked); frame_done pulses every 16 cycles.
- Write wr_data=16'h4321, wr_blank=0000 mid-frame -> wr_ready drops the next cycle; the display is unchanged until the boundary; then digit0 seg=0110000, d1=1101101, d2=1111001, d3=0110011; wr_ready returns to 1.
- Write 16'hFA09 -> d0=1111011, d1=1111110, d2=1001111 ("E"), d3=1001111.
- A second wr_en while wr_ready=0, then a boundary -> only the first frame is displayed; the second write is lost and the bench sees wr_ready=0 on that cycle.
- wr_blank=0100 with data 16'h8888 -> d2 slot has sel=1011, seg=0000000; the other slots show 1111111.
- enable=0 with a pending write -> sel=1111, seg=0, commit on the next cycle. Re-enable -> sel=1110 one cycle later, showing the new d0. Assert rst_n=0 mid-frame -> outputs return to reset values asynchronously.
